// File: rtl/player_input_debouncer.sv
// Player input conditioning: per-bit two-flop synchroniser, debounce counter and
// registered press-event pulse feeding the player PIO in_port.
module player_input_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW_IN   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic             any_press
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] RELEASED = (ACTIVE_LOW_IN != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] syncMeta_q;
    logic [WIDTH-1:0] syncStable_q;
    logic [WIDTH-1:0] syncActive;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [CNT_W-1:0] count_q [WIDTH];
    logic [CNT_W-1:0] count_d [WIDTH];

    // XOR with the released pattern turns the synchronised pins into active-high "pressed".
    assign syncActive = syncStable_q ^ RELEASED;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta_q   <= RELEASED;
            syncStable_q <= RELEASED;
            level_q      <= '0;
            press_q      <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            syncMeta_q   <= btn_raw;
            syncStable_q <= syncMeta_q;
            level_q      <= level_d;
            press_q      <= press_d;
            for (int i = 0; i < WIDTH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    // Each bit is STABLE while its synchronised input matches the committed level and
    // COUNTING otherwise; any return to the committed value restarts the count.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_d[i] = count_q[i];
            if (syncActive[i] == level_q[i]) begin
                count_d[i] = '0;
            end else if (count_q[i] == TERMINAL) begin
                level_d[i] = syncActive[i];
                press_d[i] = syncActive[i];
                count_d[i] = '0;
            end else begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign any_press = |press_q;

endmodule

// File: tb/tb_player_input_debouncer.sv
// Directed bench for player_input_debouncer with DEBOUNCE_CYCLES = 4, active-low pins.
module tb_player_input_debouncer;

    logic       clk;
    logic       reset_n;
    logic [7:0] btn_raw;
    logic [7:0] btn_level;
    logic [7:0] btn_press;
    logic       any_press;

    int checks;
    int errors;
    logic [7:0] pressedMask;

    player_input_debouncer #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW_IN(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyPins();
        btn_raw = ~pressedMask;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        pressedMask = 8'h00;
        applyPins();
        #12;
        checks++;
        if (btn_level !== 8'h00 || btn_press !== 8'h00 || any_press !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: level=%h press=%h any=%b expected 00/00/0", btn_level, btn_press, any_press);
        end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (btn_level !== 8'h00 || btn_press !== 8'h00 || any_press !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: level=%h press=%h any=%b expected 00/00/0", k, btn_level, btn_press, any_press);
            end
        end
    endtask

    // Press the bits in newBits now (before E0) and check edges E0..E6.
    task automatic pressAndCheck(input string name, input logic [7:0] newBits,
                                 input logic [7:0] levelBefore, input logic [7:0] levelAfter);
        logic [7:0] expLevel;
        logic [7:0] expPress;
        pressedMask = pressedMask | newBits;
        applyPins();
        for (int k = 0; k < 7; k++) begin
            tick();
            expLevel = (k >= 5) ? levelAfter : levelBefore;
            expPress = (k == 5) ? newBits : 8'h00;
            checks++;
            if (btn_level !== expLevel || btn_press !== expPress || any_press !== (expPress != 8'h00)) begin
                errors++;
                $display("[TB] FAIL %s E%0d: level=%h press=%h any=%b expected %h/%h/%b",
                         name, k, btn_level, btn_press, any_press, expLevel, expPress, (expPress != 8'h00));
            end
        end
    endtask

    task automatic test_single_press();
        pressAndCheck("single_press", 8'h01, 8'h00, 8'h01);
    endtask

    task automatic test_bounce();
        logic [3:0] pattern [11];
        pattern = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        for (int k = 0; k < 11; k++) begin
            pressedMask[3] = (pattern[k] == 4'd0);
            applyPins();
            tick();
            checks++;
            if (btn_level !== 8'h01 || btn_press !== 8'h00) begin
                errors++;
                $display("[TB] FAIL bounce step %0d: level=%h press=%h expected 01/00", k, btn_level, btn_press);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        checks++;
        if (btn_level !== 8'h01) begin
            errors++;
            $display("[TB] FAIL bounce_settle: level=%h expected 01", btn_level);
        end
        pressedMask[3] = 1'b0;
        pressAndCheck("bounce_commit", 8'h08, 8'h01, 8'h09);
    endtask

    task automatic test_back_to_back();
        pressAndCheck("simultaneous", 8'h42, 8'h09, 8'h4B);
    endtask

    task automatic test_release();
        pressAndCheck("press_bit2", 8'h04, 8'h4B, 8'h4F);
        pressedMask[2] = 1'b0;
        applyPins();
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (btn_level !== ((k >= 5) ? 8'h4B : 8'h4F) || btn_press !== 8'h00 || any_press !== 1'b0) begin
                errors++;
                $display("[TB] FAIL release E%0d: level=%h press=%h any=%b expected %h/00/0",
                         k, btn_level, btn_press, any_press, ((k >= 5) ? 8'h4B : 8'h4F));
            end
        end
    endtask

    task automatic test_reset_mid_count();
        pressedMask[5] = 1'b1;
        applyPins();
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (btn_level !== 8'h00 || btn_press !== 8'h00 || any_press !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: level=%h press=%h any=%b expected 00/00/0", btn_level, btn_press, any_press);
        end
        tick();
        checks++;
        if (btn_level !== 8'h00 || btn_press !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_held: level=%h press=%h expected 00/00", btn_level, btn_press);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (btn_level !== ((k >= 5) ? 8'h6B : 8'h00) || btn_press !== ((k == 5) ? 8'h6B : 8'h00)) begin
                errors++;
                $display("[TB] FAIL post_reset R%0d: level=%h press=%h expected %h/%h",
                         k, btn_level, btn_press, ((k >= 5) ? 8'h6B : 8'h00), ((k == 5) ? 8'h6B : 8'h00));
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        btn_raw = 8'hFF;
        test_reset();
        test_single_press();
        test_bounce();
        test_back_to_back();
        test_release();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
